// File: rtl/bit_ring_writer.sv
// Write side of a bit-to-byte ring buffer: serial bits go to a 1-bit RAM port,
// frames are padded to a byte boundary and committed as a byte pointer.
module bit_ring_writer #(
  parameter logic PAD_BIT = 1'b0
) (
  input  logic        CLKA,
  input  logic        RSTB,
  input  logic        BIT_IN,
  input  logic        BIT_VALID,
  output logic        BIT_READY,
  input  logic        FRAME_END,
  input  logic [9:0]  RD_BYTE_PTR,
  output logic [11:0] ADDRA,
  output logic        DIA,
  output logic        ENA,
  output logic        WEA,
  output logic [9:0]  WR_BYTE_PTR,
  output logic        FRAME_DONE,
  output logic [15:0] FRAME_BYTES
);

  typedef enum logic [1:0] {RUN, PAD, DONE} state_t;

  state_t      state_q, state_d;
  logic [12:0] wp_q, wp_d;
  logic [11:0] addra_q, addra_d;
  logic        dia_q, dia_d;
  logic        ena_q, ena_d;
  logic        last_q, last_d;
  logic [9:0]  wr_ptr_q, wr_ptr_d;
  logic        frame_done_q, frame_done_d;
  logic [15:0] frame_bytes_q, frame_bytes_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;

  logic        full;
  logic        ready;
  logic        accept;
  logic        byte_done;
  logic [15:0] frame_cnt_inc;

  // Full when the byte being filled is the one the reader has not consumed yet,
  // one lap behind (wrap bits differ).
  assign full   = (wp_q[12:3] == {~RD_BYTE_PTR[9], RD_BYTE_PTR[8:0]});
  assign ready  = !RSTB && (state_q == RUN) && !full;
  assign accept = BIT_VALID && ready;

  // A byte is committed once its bit 7 write has landed in the RAM.
  assign byte_done     = ena_q && (addra_q[2:0] == 3'b111);
  assign frame_cnt_inc = (frame_cnt_q == 16'hFFFF) ? 16'hFFFF : frame_cnt_q + 16'd1;

  always_comb begin
    state_d       = state_q;
    wp_d          = wp_q;
    addra_d       = addra_q;
    dia_d         = dia_q;
    ena_d         = 1'b0;
    last_d        = 1'b0;
    wr_ptr_d      = wr_ptr_q;
    frame_done_d  = 1'b0;
    frame_bytes_d = frame_bytes_q;
    frame_cnt_d   = frame_cnt_q;

    case (state_q)
      RUN: begin
        if (accept) begin
          ena_d   = 1'b1;
          addra_d = wp_q[11:0];
          dia_d   = BIT_IN;
          wp_d    = wp_q + 13'd1;
          if (FRAME_END) begin
            if (wp_q[2:0] == 3'b111) begin
              state_d = DONE;
              last_d  = 1'b1;
            end else begin
              state_d = PAD;
            end
          end
        end
      end
      PAD: begin
        ena_d   = 1'b1;
        addra_d = wp_q[11:0];
        dia_d   = PAD_BIT;
        wp_d    = wp_q + 13'd1;
        if (wp_q[2:0] == 3'b111) begin
          state_d = DONE;
          last_d  = 1'b1;
        end
      end
      DONE: state_d = RUN;
      default: state_d = RUN;
    endcase

    if (byte_done) begin
      wr_ptr_d = wr_ptr_q + 10'd1;
      if (last_q) begin
        frame_done_d  = 1'b1;
        frame_bytes_d = frame_cnt_inc;
        frame_cnt_d   = 16'd0;
      end else begin
        frame_cnt_d = frame_cnt_inc;
      end
    end
  end

  always_ff @(posedge CLKA) begin
    if (RSTB) begin
      state_q       <= RUN;
      wp_q          <= 13'd0;
      addra_q       <= 12'd0;
      dia_q         <= 1'b0;
      ena_q         <= 1'b0;
      last_q        <= 1'b0;
      wr_ptr_q      <= 10'd0;
      frame_done_q  <= 1'b0;
      frame_bytes_q <= 16'd0;
      frame_cnt_q   <= 16'd0;
    end else begin
      state_q       <= state_d;
      wp_q          <= wp_d;
      addra_q       <= addra_d;
      dia_q         <= dia_d;
      ena_q         <= ena_d;
      last_q        <= last_d;
      wr_ptr_q      <= wr_ptr_d;
      frame_done_q  <= frame_done_d;
      frame_bytes_q <= frame_bytes_d;
      frame_cnt_q   <= frame_cnt_d;
    end
  end

  assign BIT_READY   = ready;
  assign ADDRA       = addra_q;
  assign DIA         = dia_q;
  assign ENA         = ena_q;
  assign WEA         = ena_q;
  assign WR_BYTE_PTR = wr_ptr_q;
  assign FRAME_DONE  = frame_done_q;
  assign FRAME_BYTES = frame_bytes_q;

endmodule

// File: tb/tb_bit_ring_writer.sv
// Directed bench for bit_ring_writer with a behavioural model of the 1-bit RAM port.
module tb_bit_ring_writer;

  logic        CLKA = 1'b0;
  logic        RSTB = 1'b1;
  logic        BIT_IN = 1'b0;
  logic        BIT_VALID = 1'b0;
  logic        BIT_READY;
  logic        FRAME_END = 1'b0;
  logic [9:0]  RD_BYTE_PTR = 10'd0;
  logic [11:0] ADDRA;
  logic        DIA;
  logic        ENA;
  logic        WEA;
  logic [9:0]  WR_BYTE_PTR;
  logic        FRAME_DONE;
  logic [15:0] FRAME_BYTES;

  int n_cmp = 0;
  int n_err = 0;
  logic ram [0:4095];

  bit_ring_writer #(.PAD_BIT(1'b0)) dut (
    .CLKA(CLKA), .RSTB(RSTB), .BIT_IN(BIT_IN), .BIT_VALID(BIT_VALID),
    .BIT_READY(BIT_READY), .FRAME_END(FRAME_END), .RD_BYTE_PTR(RD_BYTE_PTR),
    .ADDRA(ADDRA), .DIA(DIA), .ENA(ENA), .WEA(WEA), .WR_BYTE_PTR(WR_BYTE_PTR),
    .FRAME_DONE(FRAME_DONE), .FRAME_BYTES(FRAME_BYTES)
  );

  always #5 CLKA = ~CLKA;

  always @(posedge CLKA) if (ENA && WEA) ram[ADDRA] <= DIA;

  function automatic logic [7:0] ram_byte(input int b);
    logic [7:0] v;
    for (int i = 0; i < 8; i++) v[i] = ram[b * 8 + i];
    return v;
  endfunction

  task automatic tick();
    @(posedge CLKA);
    #1;
  endtask

  task automatic do_reset();
    RSTB = 1'b1; BIT_VALID = 1'b0; FRAME_END = 1'b0; RD_BYTE_PTR = 10'd0;
    tick(); tick();
    RSTB = 1'b0;
    #1;
  endtask

  // Present one bit, wait (bounded) for ready, complete the handshake.
  task automatic send_bit(input logic b, input logic fe);
    int n;
    n = 0;
    BIT_IN = b; BIT_VALID = 1'b1; FRAME_END = fe;
    while (!BIT_READY && n < 100) begin tick(); n++; end
    if (n >= 100) begin
      n_cmp++; n_err++;
      $display("FAIL send_timeout: BIT_READY=%0b after %0d cycles, required 1", BIT_READY, n);
    end
    tick();
    BIT_VALID = 1'b0; FRAME_END = 1'b0;
  endtask

  task automatic test_reset();
    RSTB = 1'b1;
    tick(); tick();
    n_cmp++; if (ADDRA !== 12'd0) begin n_err++; $display("FAIL reset_addra: got %0h want 0", ADDRA); end
    n_cmp++; if (ENA !== 1'b0 || WEA !== 1'b0) begin n_err++; $display("FAIL reset_en: got ena=%0b wea=%0b want 0", ENA, WEA); end
    n_cmp++; if (DIA !== 1'b0) begin n_err++; $display("FAIL reset_dia: got %0b want 0", DIA); end
    n_cmp++; if (WR_BYTE_PTR !== 10'd0) begin n_err++; $display("FAIL reset_wrptr: got %0h want 0", WR_BYTE_PTR); end
    n_cmp++; if (FRAME_DONE !== 1'b0 || FRAME_BYTES !== 16'd0) begin n_err++; $display("FAIL reset_frame: got done=%0b bytes=%0h want 0/0", FRAME_DONE, FRAME_BYTES); end
    n_cmp++; if (BIT_READY !== 1'b0) begin n_err++; $display("FAIL reset_ready_held: got %0b want 0", BIT_READY); end
    RSTB = 1'b0;
    #1;
    n_cmp++; if (BIT_READY !== 1'b1) begin n_err++; $display("FAIL reset_ready_release: got %0b want 1", BIT_READY); end
    $display("test_reset: done");
  endtask

  task automatic test_byte_frame();
    logic [7:0] pat;
    pat = 8'h4D;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      send_bit(pat[i], i == 7);
      n_cmp++; if (ADDRA !== 12'(i) || ENA !== 1'b1 || DIA !== pat[i]) begin n_err++; $display("FAIL byte_write%0d: got addr=%0d en=%0b d=%0b want %0d/1/%0b", i, ADDRA, ENA, DIA, i, pat[i]); end
    end
    n_cmp++; if (BIT_READY !== 1'b0) begin n_err++; $display("FAIL byte_done_ready: got %0b want 0", BIT_READY); end
    tick();
    n_cmp++; if (ENA !== 1'b0) begin n_err++; $display("FAIL byte_no_pad: got ena=%0b want 0", ENA); end
    n_cmp++; if (WR_BYTE_PTR !== 10'd1) begin n_err++; $display("FAIL byte_wrptr: got %0d want 1", WR_BYTE_PTR); end
    n_cmp++; if (FRAME_DONE !== 1'b1 || FRAME_BYTES !== 16'd1) begin n_err++; $display("FAIL byte_frame_done: got done=%0b bytes=%0d want 1/1", FRAME_DONE, FRAME_BYTES); end
    n_cmp++; if (ram_byte(0) !== 8'h4D) begin n_err++; $display("FAIL byte_ram: got %02h want 4d", ram_byte(0)); end
    tick();
    n_cmp++; if (FRAME_DONE !== 1'b0) begin n_err++; $display("FAIL byte_done_pulse: got %0b want 0", FRAME_DONE); end
    $display("test_byte_frame: wr_ptr=%0d bytes=%0d", WR_BYTE_PTR, FRAME_BYTES);
  endtask

  task automatic test_pad();
    do_reset();
    for (int i = 0; i < 12; i++) begin
      send_bit(1'b1, i == 11);
      n_cmp++; if (ADDRA !== 12'(i)) begin n_err++; $display("FAIL pad_addr%0d: got %0d want %0d", i, ADDRA, i); end
      if (i == 8) begin
        n_cmp++; if (WR_BYTE_PTR !== 10'd1) begin n_err++; $display("FAIL pad_first_commit: got %0d want 1", WR_BYTE_PTR); end
      end
    end
    for (int k = 12; k < 16; k++) begin
      n_cmp++; if (BIT_READY !== 1'b0) begin n_err++; $display("FAIL pad_ready%0d: got %0b want 0", k, BIT_READY); end
      tick();
      n_cmp++; if (ADDRA !== 12'(k) || DIA !== 1'b0 || ENA !== 1'b1) begin n_err++; $display("FAIL pad_write%0d: got addr=%0d d=%0b en=%0b want %0d/0/1", k, ADDRA, DIA, ENA, k); end
    end
    n_cmp++; if (BIT_READY !== 1'b0) begin n_err++; $display("FAIL pad_done_ready: got %0b want 0", BIT_READY); end
    tick();
    n_cmp++; if (WR_BYTE_PTR !== 10'd2 || FRAME_DONE !== 1'b1 || FRAME_BYTES !== 16'd2) begin n_err++; $display("FAIL pad_commit: got ptr=%0d done=%0b bytes=%0d want 2/1/2", WR_BYTE_PTR, FRAME_DONE, FRAME_BYTES); end
    n_cmp++; if (ram_byte(1) !== 8'h0F) begin n_err++; $display("FAIL pad_ram: got %02h want 0f", ram_byte(1)); end
    send_bit(1'b1, 1'b0);
    n_cmp++; if (ADDRA !== 12'd16) begin n_err++; $display("FAIL pad_next_frame: got %0d want 16", ADDRA); end
    $display("test_pad: wr_ptr=%0d bytes=%0d", WR_BYTE_PTR, FRAME_BYTES);
  endtask

  task automatic test_full();
    int acc;
    acc = 0;
    do_reset();
    BIT_IN = 1'b1; BIT_VALID = 1'b1;
    for (int c = 0; c < 4200; c++) begin
      if (BIT_READY) acc++;
      tick();
    end
    n_cmp++; if (acc !== 4096) begin n_err++; $display("FAIL full_accepted: got %0d want 4096", acc); end
    n_cmp++; if (WR_BYTE_PTR !== 10'h200) begin n_err++; $display("FAIL full_wrptr: got %0h want 200", WR_BYTE_PTR); end
    n_cmp++; if (BIT_READY !== 1'b0) begin n_err++; $display("FAIL full_ready: got %0b want 0", BIT_READY); end
    RD_BYTE_PTR = 10'd1;
    #1;
    n_cmp++; if (BIT_READY !== 1'b1) begin n_err++; $display("FAIL full_release: got %0b want 1", BIT_READY); end
    tick();
    BIT_VALID = 1'b0;
    n_cmp++; if (ADDRA !== 12'd0 || ENA !== 1'b1) begin n_err++; $display("FAIL full_next_addr: got addr=%0d en=%0b want 0/1", ADDRA, ENA); end
    $display("test_full: accepted=%0d wr_ptr=%0h", acc, WR_BYTE_PTR);
  endtask

  task automatic test_wrap();
    int stalls, bad_addr, bytes;
    logic saw_wrap;
    logic [11:0] prev;
    stalls = 0; bad_addr = 0; saw_wrap = 1'b0; prev = 12'd0;
    do_reset();
    BIT_IN = 1'b0; BIT_VALID = 1'b1;
    for (int idx = 0; idx < 5000; idx++) begin
      bytes = idx / 8;
      RD_BYTE_PTR = (bytes >= 100) ? 10'(bytes - 100) : 10'd0;
      BIT_IN = idx[0] ^ idx[3];
      #1;
      if (!BIT_READY) stalls++;
      tick();
      if (ADDRA !== 12'(idx % 4096)) bad_addr++;
      if (idx > 0 && prev == 12'd4095 && ADDRA == 12'd0) saw_wrap = 1'b1;
      prev = ADDRA;
    end
    BIT_VALID = 1'b0;
    tick();
    n_cmp++; if (stalls !== 0) begin n_err++; $display("FAIL wrap_stalls: got %0d want 0", stalls); end
    n_cmp++; if (bad_addr !== 0) begin n_err++; $display("FAIL wrap_addr_seq: got %0d bad addresses want 0", bad_addr); end
    n_cmp++; if (saw_wrap !== 1'b1) begin n_err++; $display("FAIL wrap_seen: got %0b want 1", saw_wrap); end
    n_cmp++; if (WR_BYTE_PTR !== 10'd625) begin n_err++; $display("FAIL wrap_wrptr: got %0h want 271", WR_BYTE_PTR); end
    $display("test_wrap: wr_ptr=%0h stalls=%0d", WR_BYTE_PTR, stalls);
  endtask

  task automatic test_gap();
    logic [7:0] pat;
    pat = 8'hA5;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      send_bit(pat[i], i == 7);
      n_cmp++; if (ADDRA !== 12'(i) || ENA !== 1'b1 || DIA !== pat[i]) begin n_err++; $display("FAIL gap_write%0d: got addr=%0d en=%0b d=%0b", i, ADDRA, ENA, DIA); end
      if (i < 7) begin
        BIT_VALID = 1'b0; FRAME_END = 1'b1; BIT_IN = ~pat[i + 1];
        tick();
        FRAME_END = 1'b0;
        n_cmp++; if (ENA !== 1'b0 || BIT_READY !== 1'b1) begin n_err++; $display("FAIL gap_idle%0d: got en=%0b ready=%0b want 0/1", i, ENA, BIT_READY); end
      end
    end
    tick();
    n_cmp++; if (WR_BYTE_PTR !== 10'd1 || FRAME_BYTES !== 16'd1 || FRAME_DONE !== 1'b1) begin n_err++; $display("FAIL gap_commit: got ptr=%0d bytes=%0d done=%0b want 1/1/1", WR_BYTE_PTR, FRAME_BYTES, FRAME_DONE); end
    n_cmp++; if (ram_byte(0) !== 8'hA5) begin n_err++; $display("FAIL gap_ram: got %02h want a5", ram_byte(0)); end
    $display("test_gap: byte0=%02h", ram_byte(0));
  endtask

  task automatic test_reset_in_pad();
    do_reset();
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b1);
    tick();
    n_cmp++; if (ADDRA !== 12'd3 || ENA !== 1'b1) begin n_err++; $display("FAIL rpad_padding: got addr=%0d en=%0b want 3/1", ADDRA, ENA); end
    RSTB = 1'b1;
    tick();
    n_cmp++; if (ADDRA !== 12'd0 || ENA !== 1'b0 || WEA !== 1'b0 || DIA !== 1'b0) begin n_err++; $display("FAIL rpad_outputs: got addr=%0d en=%0b we=%0b d=%0b want 0", ADDRA, ENA, WEA, DIA); end
    n_cmp++; if (WR_BYTE_PTR !== 10'd0 || FRAME_DONE !== 1'b0 || FRAME_BYTES !== 16'd0) begin n_err++; $display("FAIL rpad_ptrs: got ptr=%0d done=%0b bytes=%0d want 0", WR_BYTE_PTR, FRAME_DONE, FRAME_BYTES); end
    RSTB = 1'b0;
    #1;
    n_cmp++; if (BIT_READY !== 1'b1) begin n_err++; $display("FAIL rpad_ready: got %0b want 1", BIT_READY); end
    send_bit(1'b1, 1'b0);
    n_cmp++; if (ADDRA !== 12'd0 || ENA !== 1'b1) begin n_err++; $display("FAIL rpad_next_addr: got addr=%0d en=%0b want 0/1", ADDRA, ENA); end
    $display("test_reset_in_pad: done");
  endtask

  initial begin
    tick();
    test_reset();
    test_byte_frame();
    test_pad();
    test_full();
    test_wrap();
    test_gap();
    test_reset_in_pad();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/bit_ring_writer.md
Name: bit_ring_writer

Overview:
- Write-side controller for the 4096x1 / 512x8 dual-port block RAM, used as a bit-to-byte ring buffer.
- Accepts a serial bit stream with a valid/ready handshake and writes each bit to RAM port A (1-bit side) at sequential addresses.
- Pads each frame to a byte boundary and publishes a committed byte pointer to the downstream byte reader on port B (8-bit side).
- Stalls the producer when the ring holds 512 unread bytes.

Parameters:
- PAD_BIT, 1'b0, bit value written while padding a frame tail to a byte boundary.

Ports:
- CLKA  in  1  clock; all logic is on the rising edge.
- RSTB  in  1  reset, synchronous, active-high.
- BIT_IN  in  1  serial data bit.
- BIT_VALID  in  1  BIT_IN is valid.
- BIT_READY  out  1  block can accept a bit this cycle.
- FRAME_END  in  1  the accepted bit is the last bit of its frame; sampled only on a handshake.
- RD_BYTE_PTR  in  10  reader's next byte to read: [8:0] byte address, [9] wrap bit.
- ADDRA  out  12  RAM port A bit address.
- DIA  out  1  RAM port A write data.
- ENA  out  1  RAM port A enable.
- WEA  out  1  RAM port A write enable.
- WR_BYTE_PTR  out  10  committed byte pointer: [8:0] address, [9] wrap bit.
- FRAME_DONE  out  1  one-cycle pulse marking frame commit.
- FRAME_BYTES  out  16  byte count of the last completed frame, saturating at 16'hFFFF.

Behaviour:
- Reset values (RSTB high at a clock edge):
  - Outputs: ADDRA=0, DIA=0, ENA=0, WEA=0, WR_BYTE_PTR=0, FRAME_DONE=0, FRAME_BYTES=0.
  - Internal: 13-bit bit pointer wp=0, frame byte counter=0, state=RUN.
  - BIT_READY is 0 while RSTB is high.
- A reset mid-frame discards the partial frame; the reader must be reset together with this block.
- Handshake: a bit is accepted on a rising edge where BIT_VALID=1 and BIT_READY=1.
- BIT_READY = (state==RUN) and not full. It is combinational from registered state and RD_BYTE_PTR.
- Full condition: wp[12:3] == {~RD_BYTE_PTR[9], RD_BYTE_PTR[8:0]}.
  - At full, the current write byte is still unread by the reader.
  - When RD_BYTE_PTR advances, BIT_READY rises in the same cycle.
- Write path (registered; RAM write latency is 1):
  - Acceptance at edge N sets ADDRA=wp[11:0], DIA=BIT_IN, ENA=WEA=1 for the cycle after N, and wp increments (wraps 8191->0).
  - The RAM captures the bit at edge N+1.
  - ENA=WEA=0 in every cycle with no write.
- Commit rules:
  - When the written bit has address[2:0]=7, WR_BYTE_PTR increments at edge N+1 (mod 1024), i.e. after the RAM write lands.
  - WR_BYTE_PTR never exceeds RD_BYTE_PTR by more than 512 bytes.
- State machine: RUN, PAD, DONE.
  - RUN: accept bits.
    - FRAME_END accepted with the bit at wp[2:0]=7 -> DONE.
    - FRAME_END accepted with any other wp[2:0] -> PAD.
  - PAD: BIT_READY=0. Write PAD_BIT once per cycle at consecutive addresses until the byte's bit 7 is written, then -> DONE. Padding never checks full, because it stays within the current byte.
  - DONE: BIT_READY=0 for one cycle, then -> RUN.
- FRAME_DONE:
  - Pulses for exactly one cycle: the first cycle in which WR_BYTE_PTR includes the frame's last byte.
  - FRAME_BYTES is updated in that same cycle with the frame's byte count, including the padded byte.
  - The frame byte counter clears for the next frame.
- FRAME_END with BIT_VALID=0, or while BIT_READY=0, is ignored.
- A single-bit frame (FRAME_END on its first bit) yields 7 pad cycles and FRAME_BYTES=1.

Test Plan:
- Reset, then bits 1,0,1,1,0,0,1,0 with FRAME_END on the 8th, RD_BYTE_PTR=0 -> ADDRA 0..7, no PAD cycles; WR_BYTE_PTR=1; FRAME_DONE one pulse; FRAME_BYTES=1; the byte reads 8'h4D on port B.
- 12-bit frame from wp=0 -> bits written at 0..11; WR_BYTE_PTR=1 after bit 7; PAD_BIT written at 12..15 over 4 cycles with BIT_READY=0; then WR_BYTE_PTR=2, FRAME_BYTES=2; the next frame's first bit goes to ADDRA=16.
- RD_BYTE_PTR held at 0, continuous BIT_VALID -> exactly 4096 bits accepted; WR_BYTE_PTR=10'h200; BIT_READY=0. Set RD_BYTE_PTR=1 -> BIT_READY=1 in the same cycle; next write goes to ADDRA=0.
- Wrap-around: reader tracks the writer, 5000 bits streamed -> ADDRA wraps 4095->0; WR_BYTE_PTR[9] toggles after byte 511; no stall when RD_BYTE_PTR lags by 100 bytes or less.
- BIT_VALID toggled every other cycle with FRAME_END asserted while BIT_VALID=0 -> FRAME_END ignored; only qualified bits are written.
- RSTB asserted during PAD -> next cycle all outputs are at reset values, BIT_READY=1 after RSTB deasserts, and the next bit is written to ADDRA=0.
